control_sequencer: RTL and testbench

- Microprogrammed control sequencer for the ARM-subset datapath; consumes the 6-bit execute-state code from the instruction encoder.
- Holds the state register and steps through the fetch, decode and execute states.
- Emits Moore-style datapath strobes: register loads, memory enable and memory direction.
- Waits on memory-operation-complete (moc) for every memory access.

---
 rtl/control_sequencer.sv | 158 +++++++++++++++
 tb/tb_control_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: fetch / decode / execute state sequencer for the
// ARM-subset datapath. Strobes are registered alongside the state register,
// so every output is a function of registered state only.
// Optional build macro: MOC_WATCHDOG_EN adds a moc timeout (MOC_TIMEOUT
// wait cycles) that aborts the access back to state 1 and sets sticky fault.
//
//  state | meaning
//  ------+-------------------------------------------------
//    0   | reset
//    1   | MAR <- PC
//    2   | PC <- PC+4, instruction read, wait for moc
//    3   | IR <- MDR
//    4   | decode (cond / enc_state)
//  10-12 | ADD variants: register file + flags
//   13   | CMP: flags only
//   14   | MOV: register file
//   20   | LDR address: MAR load
//   21   | LDR read, wait for moc
//   22   | LDR write-back to register file
//   25   | STR address: MAR load
//   26   | STR data: MDR load
//   27   | STR write, wait for moc
//   30   | B: PC load
module control_sequencer #(
    parameter int STATE_W     = 6,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] enc_state,
    input  logic               cond,
    input  logic               moc,
    output logic [STATE_W-1:0] state,
    output logic               ir_ld,
    output logic               pc_ld,
    output logic               mar_ld,
    output logic               mdr_ld,
    output logic               rf_ld,
    output logic               fr_ld,
    output logic               mem_en,
    output logic               mem_rw,
    output logic               illegal,
    output logic               fault
);

    typedef enum logic [STATE_W-1:0] {
        S_RESET     = 0,
        S_MAR_PC    = 1,
        S_FETCH     = 2,
        S_IR_LD     = 3,
        S_DECODE    = 4,
        S_ADD0      = 10,
        S_ADD1      = 11,
        S_ADD2      = 12,
        S_CMP       = 13,
        S_MOV       = 14,
        S_LDR_ADDR  = 20,
        S_LDR_READ  = 21,
        S_LDR_WB    = 22,
        S_STR_ADDR  = 25,
        S_STR_DATA  = 26,
        S_STR_WRITE = 27,
        S_BRANCH    = 30
    } state_t;

    typedef logic [$clog2(MOC_TIMEOUT+1)-1:0] wcnt_t;

    state_t state_q;
    state_t state_nxt;
    logic   illegal_nxt;
    logic   wait_abort;

`ifdef MOC_WATCHDOG_EN
    wcnt_t wcnt_q;
    logic  fault_q;

    assign wait_abort = !moc && (wcnt_q == wcnt_t'(MOC_TIMEOUT - 1));
    assign fault      = fault_q;
`else
    assign wait_abort = 1'b0;
    assign fault      = 1'b0;
`endif

    assign state = state_q;

    // next-state selection; wait states hold until moc (or watchdog abort)
    always_comb begin
        state_nxt   = S_MAR_PC;
        illegal_nxt = 1'b0;
        case (state_q)
            S_RESET:     state_nxt = S_MAR_PC;
            S_MAR_PC:    state_nxt = S_FETCH;
            S_FETCH:     state_nxt = moc ? S_IR_LD : (wait_abort ? S_MAR_PC : S_FETCH);
            S_IR_LD:     state_nxt = S_DECODE;
            S_DECODE: begin
                if (!cond) begin
                    state_nxt = S_MAR_PC;
                end else if (enc_state inside {S_ADD0, S_ADD1, S_ADD2, S_CMP, S_MOV,
                                               S_LDR_ADDR, S_STR_ADDR, S_BRANCH}) begin
                    state_nxt = state_t'(enc_state);
                end else begin
                    state_nxt   = S_MAR_PC;
                    illegal_nxt = 1'b1;
                end
            end
            S_LDR_ADDR:  state_nxt = S_LDR_READ;
            S_LDR_READ:  state_nxt = moc ? S_LDR_WB : (wait_abort ? S_MAR_PC : S_LDR_READ);
            S_STR_ADDR:  state_nxt = S_STR_DATA;
            S_STR_DATA:  state_nxt = S_STR_WRITE;
            S_STR_WRITE: state_nxt = (moc || wait_abort) ? S_MAR_PC : S_STR_WRITE;
            default:     state_nxt = S_MAR_PC;
        endcase
    end

    // state register with strobes registered from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            ir_ld   <= 1'b0;
            pc_ld   <= 1'b0;
            mar_ld  <= 1'b0;
            mdr_ld  <= 1'b0;
            rf_ld   <= 1'b0;
            fr_ld   <= 1'b0;
            mem_en  <= 1'b0;
            mem_rw  <= 1'b1;
            illegal <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ir_ld   <= (state_nxt == S_IR_LD);
            // PC increment only on the first cycle of the fetch wait
            pc_ld   <= ((state_nxt == S_FETCH) && (state_q != S_FETCH)) ||
                       (state_nxt == S_BRANCH);
            mar_ld  <= state_nxt inside {S_MAR_PC, S_LDR_ADDR, S_STR_ADDR};
            mdr_ld  <= state_nxt inside {S_FETCH, S_LDR_READ, S_STR_DATA};
            rf_ld   <= state_nxt inside {S_ADD0, S_ADD1, S_ADD2, S_MOV, S_LDR_WB};
            fr_ld   <= state_nxt inside {S_ADD0, S_ADD1, S_ADD2, S_CMP};
            mem_en  <= state_nxt inside {S_FETCH, S_LDR_READ, S_STR_WRITE};
            mem_rw  <= (state_nxt != S_STR_WRITE);
            illegal <= illegal_nxt;
        end
    end

`ifdef MOC_WATCHDOG_EN
    // wait-cycle counter (clears on any state change) and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wcnt_q <= (state_nxt != state_q) ? '0 : wcnt_q + 1'b1;
            if (wait_abort && (state_q inside {S_FETCH, S_LDR_READ, S_STR_WRITE}))
                fault_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer. A reference model expands each
// instruction (opcode, cond, moc delays) into its expected cycle trace; the
// driver applies inputs per cycle and a monitor compares at each negedge.
module tb_control_sequencer;

    localparam int STATE_W     = 6;
    localparam int MOC_TIMEOUT = 15;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [STATE_W-1:0] enc_state = '0;
    logic               cond = 1'b0;
    logic               moc = 1'b0;
    logic [STATE_W-1:0] state;
    logic ir_ld, pc_ld, mar_ld, mdr_ld, rf_ld, fr_ld, mem_en, mem_rw, illegal, fault;

    control_sequencer #(.STATE_W(STATE_W), .MOC_TIMEOUT(MOC_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .enc_state(enc_state), .cond(cond), .moc(moc),
        .state(state), .ir_ld(ir_ld), .pc_ld(pc_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld),
        .rf_ld(rf_ld), .fr_ld(fr_ld), .mem_en(mem_en), .mem_rw(mem_rw),
        .illegal(illegal), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] st;
        logic ir, pc, mar, mdr, rf, fr, en, rw, ill, flt;
        logic moc_drv, rst_drv, cnd;
        logic [5:0] enc;
    } rec_t;

    rec_t plan[$];
    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 0;
    bit   m_illegal = 0;
    bit   m_fault = 0;
    logic [5:0] cur_enc = '0;
    logic       cur_cond = 1'b0;

    // expected strobes for one cycle spent in state st
    function automatic rec_t mk(logic [5:0] st, bit first);
        rec_t r;
        r = '{default: 0};
        r.st = st; r.rw = 1'b1; r.flt = m_fault;
        r.moc_drv = 1'($urandom_range(0, 1));
        r.enc = cur_enc; r.cnd = cur_cond;
        case (st)
            1:          r.mar = 1;
            2:          begin r.pc = first; r.en = 1; r.mdr = 1; end
            3:          r.ir = 1;
            10, 11, 12: begin r.rf = 1; r.fr = 1; end
            13:         r.fr = 1;
            14:         r.rf = 1;
            20:         r.mar = 1;
            21:         begin r.en = 1; r.mdr = 1; end
            22:         r.rf = 1;
            25:         r.mar = 1;
            26:         r.mdr = 1;
            27:         begin r.en = 1; r.rw = 0; end
            30:         r.pc = 1;
            default:    ;
        endcase
        return r;
    endfunction

    // memory wait: moc arrives after d low cycles, or the watchdog aborts
    task automatic add_wait(input logic [5:0] st, input int d, output bit aborted);
        rec_t r;
        aborted = 0;
        for (int i = 0; i <= d; i++) begin
            r = mk(st, i == 0);
            r.moc_drv = (i == d);
`ifdef MOC_WATCHDOG_EN
            if (d >= MOC_TIMEOUT && i == MOC_TIMEOUT - 1) begin
                r.moc_drv = 0;
                plan.push_back(r);
                aborted = 1;
                m_fault = 1;
                break;
            end
`endif
            plan.push_back(r);
        end
    endtask

    task automatic add_instr(input logic [5:0] op, input bit cnd, input int fd, input int md);
        rec_t r;
        bit   ab;
        cur_enc = op; cur_cond = cnd;
        r = mk(1, 0); r.ill = m_illegal; m_illegal = 0;
        plan.push_back(r);
        add_wait(2, fd, ab);
        if (ab) return;
        plan.push_back(mk(3, 0));
        plan.push_back(mk(4, 0));
        if (!cnd) return;
        case (op)
            10, 11, 12, 13, 14, 30: plan.push_back(mk(op, 0));
            20: begin
                plan.push_back(mk(20, 0));
                add_wait(21, md, ab);
                if (!ab) plan.push_back(mk(22, 0));
            end
            25: begin
                plan.push_back(mk(25, 0));
                plan.push_back(mk(26, 0));
                add_wait(27, md, ab);
            end
            default: m_illegal = 1;
        endcase
    endtask

    // reset asserted during the second cycle of a fetch wait
    task automatic add_reset_mid_fetch();
        rec_t r;
        r = mk(1, 0); r.ill = m_illegal; m_illegal = 0;
        plan.push_back(r);
        r = mk(2, 1); r.moc_drv = 0; plan.push_back(r);
        r = mk(2, 0); r.moc_drv = 0; r.rst_drv = 1; plan.push_back(r);
        m_fault = 0;
        plan.push_back(mk(0, 0));
    endtask

    task automatic add_random(input int n);
        logic [5:0] ops [13];
        ops = '{6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd20, 6'd25, 6'd30,
                6'd7, 6'd0, 6'd63, 6'd15, 6'd31};
        for (int k = 0; k < n; k++)
            add_instr(ops[$urandom_range(0, 12)], ($urandom_range(0, 4) != 0),
                      $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    // monitor: one scoreboard comparison per cycle
    always @(negedge clk) begin
        if (mon_on) begin
            rec_t e;
            logic [15:0] act, req;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow at %0t", $time);
            end else begin
                e   = exp_q.pop_front();
                act = {state, ir_ld, pc_ld, mar_ld, mdr_ld, rf_ld, fr_ld, mem_en, mem_rw, illegal, fault};
                req = {e.st, e.ir, e.pc, e.mar, e.mdr, e.rf, e.fr, e.en, e.rw, e.ill, e.flt};
                if (act !== req) begin
                    errors++;
                    $display("FAIL cycle_state_strobes t=%0t actual state=%0d bits=%b required state=%0d bits=%b",
                             $time, act[15:10], act[9:0], req[15:10], req[9:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rec_t r;
        plan.push_back(mk(0, 0));
        add_instr(6'd10, 1, 0, 0);     // ADD with immediate moc
        add_instr(6'd14, 1, 3, 0);     // fetch with moc delayed 3 cycles
        add_instr(6'd25, 1, 0, 2);     // STR with 2 wait cycles
        add_instr(6'd20, 1, 1, 1);     // LDR
        add_instr(6'd20, 0, 0, 0);     // LDR with cond=0
        add_instr(6'd7, 1, 0, 0);      // illegal code
        add_instr(6'd13, 1, 0, 0);
        add_random(25);
        add_instr(6'd20, 1, 0, 20);    // long LDR wait (watchdog abort if enabled)
        add_random(5);
        add_reset_mid_fetch();
        add_random(25);

        repeat (2) @(posedge clk);
        #1;
        mon_on = 1;
        while (plan.size() > 0) begin
            r = plan.pop_front();
            reset     = r.rst_drv;
            moc       = r.moc_drv;
            enc_state = r.enc;
            cond      = r.cnd;
            exp_q.push_back(r);
            @(posedge clk);
            #1;
        end
        mon_on = 0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
